// File: rtl/seg_display_ctrl_if.sv
// ============================================================================
// seg_display_ctrl_if : load/value handshake, live masks and scan outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface seg_display_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
);
  logic [BIN_WIDTH-1:0]  value;
  logic                  load;
  logic                  mode;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic                  busy;
  logic [6:0]            display;
  logic                  dp;
  logic [NUM_DIGITS-1:0] digit;

  modport master (
    output value, load, mode, blank_lz, dp_mask, blink_mask,
    input  busy, display, dp, digit
  );

  modport slave (
    input  value, load, mode, blank_lz, dp_mask, blink_mask,
    output busy, display, dp, digit
  );
endinterface

`default_nettype wire

// File: rtl/seg_display_ctrl.sv
// ============================================================================
// seg_display_ctrl : multiplexed 7-segment driver, hex or double-dabble decimal
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_display_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int BIN_WIDTH      = 14,
  parameter int SCAN_DIV_BITS  = 16,
  parameter int BLINK_DIV_BITS = 24
) (
  input  logic               clk,
  input  logic               rst,
  seg_display_ctrl_if.slave  bus
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  localparam int C_BCD_W  = 4 * NUM_DIGITS;
  localparam int C_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int C_ITER_W = $clog2(BIN_WIDTH + 1);
  localparam logic [C_IDX_W-1:0]  C_LAST_IDX  = C_IDX_W'(NUM_DIGITS - 1);
  localparam logic [C_ITER_W-1:0] C_LAST_ITER = C_ITER_W'(BIN_WIDTH - 1);
  localparam logic [63:0]         C_DEC_MAX   = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [6:0]          C_SEG_BLANK = 7'b1111111;
  localparam logic [6:0]          C_SEG_DASH  = 7'b0111111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [BIN_WIDTH-1:0]      bin_q, bin_d;
  logic [C_BCD_W-1:0]        bcd_q, bcd_d;
  logic [C_ITER_W-1:0]       iter_q, iter_d;
  logic                      conv_ovf_q, conv_ovf_d;
  logic [C_BCD_W-1:0]        shadow_q, shadow_d;
  logic                      shadow_ovf_q, shadow_ovf_d;
  logic [SCAN_DIV_BITS-1:0]  scan_cnt_q;
  logic [C_IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_DIV_BITS-1:0] blink_cnt_q;
  logic [6:0]                display_q, display_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     digit_q, digit_d;

  logic [C_BCD_W-1:0]        hex_w;
  logic [C_BCD_W-1:0]        bcd_adj_w;
  logic [63:0]               value_ext_w;
  logic                      over_w;
  logic [NUM_DIGITS-1:0]     lz_w;
  logic                      blink_phase_w;

  generate
    if (BIN_WIDTH >= C_BCD_W) begin : g_hex_trunc
      assign hex_w = bus.value[C_BCD_W-1:0];
    end else begin : g_hex_ext
      assign hex_w = {{(C_BCD_W - BIN_WIDTH){1'b0}}, bus.value};
    end
  endgenerate

  assign value_ext_w   = 64'(bus.value);
  assign over_w        = (value_ext_w > C_DEC_MAX);
  assign blink_phase_w = blink_cnt_q[BLINK_DIV_BITS-1];

  // Double-dabble correction step applied before each shift.
  always_comb begin
    bcd_adj_w = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj_w[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    conv_ovf_d   = conv_ovf_q;
    shadow_d     = shadow_q;
    shadow_ovf_d = shadow_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          if (bus.mode) begin
            state_d    = S_CONV;
            bin_d      = bus.value;
            bcd_d      = '0;
            iter_d     = '0;
            conv_ovf_d = over_w;
          end else begin
            shadow_d     = hex_w;
            shadow_ovf_d = 1'b0;
          end
        end
      end
      S_CONV: begin
        bcd_d  = {bcd_adj_w[C_BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_d  = bin_q << 1;
        iter_d = iter_q + C_ITER_W'(1);
        if (iter_q == C_LAST_ITER) begin
          state_d      = S_IDLE;
          shadow_d     = bcd_d;
          shadow_ovf_d = conv_ovf_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (scan_cnt_q == '1) idx_d = (idx_q == C_LAST_IDX) ? '0 : idx_q + C_IDX_W'(1);
  end

  // lz_w[i]: digit i and everything above it are zero; digit 0 always shows.
  always_comb begin : p_lz
    logic zero_run;
    zero_run = 1'b1;
    lz_w     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_q[i*4 +: 4] == 4'd0);
      lz_w[i]  = zero_run;
    end
    lz_w[0] = 1'b0;
  end

  always_comb begin : p_out
    logic [3:0] sel_nib;
    logic       sel_lz;
    logic       sel_dp;
    logic       sel_blink;
    sel_nib   = '0;
    sel_lz    = 1'b0;
    sel_dp    = 1'b0;
    sel_blink = 1'b0;
    digit_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == C_IDX_W'(i)) begin
        sel_nib    = shadow_q[i*4 +: 4];
        sel_lz     = lz_w[i];
        sel_dp     = bus.dp_mask[i];
        sel_blink  = bus.blink_mask[i];
        digit_d[i] = 1'b0;
      end
    end
    display_d = seg7(sel_nib);
    dp_d      = ~sel_dp;
    if (shadow_ovf_q)                  display_d = C_SEG_DASH;
    else if (bus.blank_lz && sel_lz)   display_d = C_SEG_BLANK;
    if (blink_phase_w && sel_blink) begin
      display_d = C_SEG_BLANK;
      dp_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      conv_ovf_q   <= 1'b0;
      shadow_q     <= '0;
      shadow_ovf_q <= 1'b0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      display_q    <= C_SEG_BLANK;
      dp_q         <= 1'b1;
      digit_q      <= '1;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      conv_ovf_q   <= conv_ovf_d;
      shadow_q     <= shadow_d;
      shadow_ovf_q <= shadow_ovf_d;
      scan_cnt_q   <= scan_cnt_q + SCAN_DIV_BITS'(1);
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_q + BLINK_DIV_BITS'(1);
      display_q    <= display_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
    end
  end

  assign bus.busy    = (state_q == S_CONV);
  assign bus.display = display_q;
  assign bus.dp      = dp_q;
  assign bus.digit   = digit_q;

endmodule

`default_nettype wire

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised multiplexed 7-segment display driver. It replaces the fixed 4-digit hex scanner used for the speed debug readout. It adds:
- a configurable digit count;
- a sequential binary-to-BCD (double-dabble) decimal mode with a load/busy handshake;
- leading-zero blanking, overflow indication, and per-digit decimal points and blinking.

It sits beside the game top level and drives the board's anodes and cathodes directly.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..8).
- BIN_WIDTH, 14: width of `value`.
- SCAN_DIV_BITS, 16: each digit is held for 2^SCAN_DIV_BITS clk cycles.
- BLINK_DIV_BITS, 24: the blink phase is the MSB of a free-running BLINK_DIV_BITS counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- value  in  BIN_WIDTH  binary number to display.
- load  in  1  single-cycle capture strobe for `value`/`mode`.
- mode  in  1  0 = hex, 1 = decimal; latched at load.
- blank_lz  in  1  enables leading-zero blanking (sampled live).
- dp_mask  in  NUM_DIGITS  bit i set = decimal point lit on digit i (live).
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks (live).
- busy  out  1  decimal conversion in progress.
- display  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- digit  out  NUM_DIGITS  anode select, one-hot active-low; bit 0 = rightmost, least significant digit.

## Operation
- Shadow register: NUM_DIGITS 4-bit codes plus an overflow flag. Scanning always reads the shadow, so a conversion in progress never shows partial digits.
- Hex mode load:
  - value is zero-extended or truncated to 4*NUM_DIGITS bits.
  - Nibble i goes to digit i.
  - Shadow updates on the load edge. busy never asserts. Overflow is cleared.
- Decimal mode load:
  - IDLE→CONV. value and the overflow flag (value > 10^NUM_DIGITS−1) are captured.
  - CONV runs BIN_WIDTH double-dabble iterations: add 3 to every BCD nibble ≥5, then shift left one bit.
  - On the last iteration the FSM goes CONV→IDLE and commits the BCD result and the overflow flag to the shadow.
- States: IDLE, CONV. load while busy is ignored (no queueing).
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Overflow set: every digit shows '-' (0111111); leading-zero blanking does not apply.
- Leading-zero blanking (blank_lz=1, no overflow): digits above the highest nonzero digit show 1111111. Digit 0 is never blanked, so zero shows as "0".
- Blink: when blink phase = 1, digits whose blink_mask bit is set show 1111111 with dp = 1. The anode is still driven.
- dp = ~dp_mask[current index], unless that digit is blinked off.

## Timing
- Scan counter (SCAN_DIV_BITS bits) free-runs. On wrap, the scan index advances: 0→1→…→NUM_DIGITS−1→0.
- display, dp and digit are registered. They are recomputed every cycle from the index, the shadow and the live masks, and all three change on the same edge.
- A shadow change is visible on the selected digit one cycle after commit.
- Decimal latency: load sampled at edge k. busy = 1 from k+1 through k+BIN_WIDTH. The shadow commits and busy = 0 at edge k+BIN_WIDTH+1.
- Reset values:
  - digit = all 1s, display = 1111111, dp = 1, busy = 0.
  - shadow = 0, overflow = 0, scan and blink counters = 0, index = 0, FSM = IDLE.
- Reset mid-conversion aborts the conversion; the shadow stays 0.
- The first scan output after reset is digit 0, driven on the first edge after rst deasserts.

## Test plan
Bench parameters: NUM_DIGITS=4, BIN_WIDTH=14, SCAN_DIV_BITS=2, BLINK_DIV_BITS=6.
- Reset → digit=1111, display=1111111, dp=1, busy=0. After release, digit cycles 1110,1101,1011,0111 every 4 clk, each showing '0' (1000000).
- Hex load 0x3EEF (mode=0) → busy stays 0. Digits 0..3 show F(0001110), E, E, 3(0110000) from the next cycle.
- Decimal load 1234 → busy high exactly 14 cycles. The shadow shows 4,3,2,1 after commit. The old value is displayed throughout the conversion.
- Decimal 7 with blank_lz=1 → digit 0 = 1111000, digits 1–3 = 1111111. Decimal 12000 → all digits 0111111.
- Load 99 during busy of a 5000 conversion → ignored, and 5000 is displayed. Assert rst mid-conversion → busy=0 and the shadow shows 0.
- dp_mask=0010, blink_mask=0001 → dp=0 only on digit 1. Digit 0 segments alternate between '0' and blank every 32 clk.
